reg_write_arbiter: RTL
======================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port RST  input  1  reset; one clock, reset synchronous active-high.
REQ-003 SHALL have port SLOW_CLOCK_STRB  input  1  one-CLK-wide enable at which registers capture.
REQ-004 SHALL have port REQ  input  4  per-requester write request, level, held until ACK.
REQ-005 SHALL have port REQ_DEST  input  12  packed 3-bit destination register index per requester.
REQ-006 SHALL have port REQ_DATA  input  64  packed 16-bit write data per requester.
REQ-007 SHALL have port REQ_MOV  input  4  per-requester byte-move flag; 1 selects MOV_EN instead of IN_EN.
REQ-008 SHALL have port ACK  output  4  one-hot, one-CLK pulse to the served requester.
REQ-009 SHALL have port BUS_DATA  output  16  shared register-file input bus.
REQ-010 SHALL have port IN_EN  output  8  one-hot full-word load enable per register.
REQ-011 SHALL have port MOV_EN  output  8  one-hot low-byte move enable per register.
REQ-012 SHALL have port BUSY  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, ARMED, ACKING.
REQ-014 IDLE: if any REQ bit set, SHALL latch winner index, its DEST, DATA, MOV and go to ARMED next cycle; else stay.
REQ-015 ARMED: BUS_DATA SHALL present latched data from the registered value, stable for the whole state.
REQ-016 ARMED with SLOW_CLOCK_STRB=1: exactly one bit of IN_EN (MOV=0) or MOV_EN (MOV=1), at latched DEST, SHALL be high in that same cycle (combinational from state and strobe); next state ACKING.
REQ-017 ARMED with SLOW_CLOCK_STRB=0: IN_EN and MOV_EN SHALL be zero; stay ARMED.
REQ-018 ACKING: ACK bit of latched winner SHALL be high for exactly one cycle; next state IDLE.
REQ-019 Latency: REQ seen in IDLE -> enable no earlier than 1 cycle later; ACK exactly 1 cycle after the enable cycle.
REQ-020 REQ, DEST, DATA, MOV changes after latching SHALL be ignored; a withdrawn REQ still completes its write and ACK.
REQ-021 A requester still asserting REQ in the cycle after ACK SHALL be treated as a new request.
REQ-022 At most one of IN_EN/MOV_EN bits SHALL be high in any cycle; both SHALL be zero outside ARMED.
REQ-023 BUS_DATA SHALL be 16'h0000 in IDLE.

Reset
REQ-024 RST=1 at a rising edge SHALL force IDLE, ACK=0, BUS_DATA=16'h0000, latched fields zero, round-robin pointer to requester 0, regardless of state.
REQ-025 Reset during ARMED SHALL abort the write with no enable pulse and no ACK; IN_EN/MOV_EN SHALL be zero in the cycle RST is high.

Configuration
REQ-026 Macro REG_ARB_ROUND_ROBIN_EN defined: winner SHALL be first requesting index at or after pointer, wrapping 3->0; pointer SHALL become winner+1 (mod 4) on entry to ACKING.
REQ-027 Macro undefined: fixed priority, lowest index wins; no pointer state.

Structure
REQ-028 Shared package sap_ctrl_pkg SHALL hold NUM_REQ=4, NUM_REGS=8, DATA_W=16, DEST_W=3 and the FSM state enum.
REQ-029 Winner selection SHALL live in sub-module rr_pick (priority/round-robin pick from REQ and pointer); FSM, latches and decode in top.

Verification
REQ-030 Single request: REQ=4'b0010, DEST1=5, DATA1=16'hBEEF, MOV=0, strobe 2 cycles after latch -> IN_EN=8'h20 in strobe cycle, BUS_DATA=16'hBEEF, ACK=4'b0010 next cycle.
REQ-031 Byte move: requester 3, DEST=0, DATA=16'h12A5, MOV=1 -> MOV_EN=8'h01, IN_EN=0, ACK=4'b1000.
REQ-032 Contention with REG_ARB_ROUND_ROBIN_EN, REQ=4'b1111 held -> ACK order 0,1,2,3,0; without macro -> 0,0,0.
REQ-033 Strobe absent 10 cycles in ARMED -> no enables, BUSY=1, no ACK; first strobe -> single enable, ACK next cycle.
REQ-034 RST asserted in ARMED coincident with strobe -> no enable, no ACK; next cycle IDLE, BUS_DATA=0.
REQ-035 Requester drops REQ after latch -> write and ACK still occur once; no second grant.

Source files
------------

// File: rtl/sap_ctrl_pkg.sv
// Shared sizes, FSM state enum and latched-request payload for the register write arbiter.
package sap_ctrl_pkg;

    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned NUM_REGS  = 8;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned DEST_W    = 3;
    localparam int unsigned REQ_IDX_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACKING = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [REQ_IDX_W-1:0] idx;
        logic [DEST_W-1:0]    dest;
        logic [DATA_W-1:0]    data;
        logic                 mov;
    } wr_req_t;

    function automatic logic [NUM_REGS-1:0] dest_onehot(input logic [DEST_W-1:0] dest);
        return NUM_REGS'(1) << dest;
    endfunction

    function automatic logic [NUM_REQ-1:0] req_onehot(input logic [REQ_IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Winner pick: round-robin from ptr_i when REG_ARB_ROUND_ROBIN_EN is defined, else lowest index.
module rr_pick
    import sap_ctrl_pkg::*;
(
    input  logic [NUM_REQ-1:0]   req_i,
`ifdef REG_ARB_ROUND_ROBIN_EN
    input  logic [REQ_IDX_W-1:0] ptr_i,
`endif
    output logic                 valid_o,
    output logic [REQ_IDX_W-1:0] idx_o
);

`ifdef REG_ARB_ROUND_ROBIN_EN
    logic [REQ_IDX_W-1:0] cand;

    // Scan from the pointer upwards; index arithmetic wraps 3->0 naturally.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            cand = REQ_IDX_W'(ptr_i + REQ_IDX_W'(k));
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end
`else
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (!valid_o && req_i[k]) begin
                valid_o = 1'b1;
                idx_o   = REQ_IDX_W'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates register-file writes from four requesters onto one bus, firing on the slow strobe.
// Build option: REG_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed lowest-index priority.
module reg_write_arbiter
    import sap_ctrl_pkg::*;
(
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       SLOW_CLOCK_STRB,
    input  logic [NUM_REQ-1:0]         REQ,
    input  logic [NUM_REQ*DEST_W-1:0]  REQ_DEST,
    input  logic [NUM_REQ*DATA_W-1:0]  REQ_DATA,
    input  logic [NUM_REQ-1:0]         REQ_MOV,
    output logic [NUM_REQ-1:0]         ACK,
    output logic [DATA_W-1:0]          BUS_DATA,
    output logic [NUM_REGS-1:0]        IN_EN,
    output logic [NUM_REGS-1:0]        MOV_EN,
    output logic                       BUSY
);

    arb_state_e           state_q;
    wr_req_t              cur_q;
    logic [DATA_W-1:0]    bus_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic                 pick_valid;
    logic [REQ_IDX_W-1:0] pick_idx;
    logic                 wr_fire;

    logic [DEST_W-1:0]    dest_arr [NUM_REQ];
    logic [DATA_W-1:0]    data_arr [NUM_REQ];

    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            dest_arr[i] = REQ_DEST[i*DEST_W +: DEST_W];
            data_arr[i] = REQ_DATA[i*DATA_W +: DATA_W];
        end
    end

`ifdef REG_ARB_ROUND_ROBIN_EN
    logic [REQ_IDX_W-1:0] ptr_q;

    rr_pick u_pick (
        .req_i   (REQ),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q <= '0;
        end else if (state_q == ST_ARMED && SLOW_CLOCK_STRB) begin
            ptr_q <= REQ_IDX_W'(cur_q.idx + REQ_IDX_W'(1));
        end
    end
`else
    rr_pick u_pick (
        .req_i   (REQ),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );
`endif

    // FSM with latched request; request inputs are ignored once latched.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            bus_q   <= '0;
            ack_q   <= '0;
        end else begin
            ack_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        cur_q   <= '{idx:  pick_idx,
                                     dest: dest_arr[pick_idx],
                                     data: data_arr[pick_idx],
                                     mov:  REQ_MOV[pick_idx]};
                        bus_q   <= data_arr[pick_idx];
                        state_q <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (SLOW_CLOCK_STRB) begin
                        ack_q   <= req_onehot(cur_q.idx);
                        state_q <= ST_ACKING;
                    end
                end
                ST_ACKING: begin
                    bus_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    bus_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Enables are same-cycle with the strobe, and suppressed while reset is asserted.
    assign wr_fire = (state_q == ST_ARMED) && SLOW_CLOCK_STRB && !RST;

    always_comb begin
        IN_EN  = '0;
        MOV_EN = '0;
        if (wr_fire) begin
            if (cur_q.mov) begin
                MOV_EN = dest_onehot(cur_q.dest);
            end else begin
                IN_EN = dest_onehot(cur_q.dest);
            end
        end
    end

    assign ACK      = ack_q;
    assign BUS_DATA = bus_q;
    assign BUSY     = (state_q != ST_IDLE);

endmodule
